// File: rtl/ram_datapath.sv
// Two small flop RAMs with auto-increment addresses. RAM B captures the
// running maximum of Hold and the current RAM A word.
module ram_datapath #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              WEA,
  input  logic              IncA,
  input  logic              WEB,
  input  logic              IncB,
  input  logic [DATA_W-1:0] DataIn,
  output logic [2:0]        AddrA,
  output logic [1:0]        AddrB,
  output logic [DATA_W-1:0] DOutA,
  output logic [DATA_W-1:0] DOutB,
  output logic              Done,
  output logic              Error
);

  logic [DATA_W-1:0] ram_a [8];
  logic [DATA_W-1:0] ram_b [4];
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] max_val;
  logic              wr_a;
  logic              wr_b;
  logic              conflict;
  logic              load_hold;

  // Simultaneous write strobes are a protocol violation: suppress both writes.
  assign conflict  = WEA & WEB;
  assign wr_a      = WEA & ~WEB;
  assign wr_b      = WEB & ~WEA;
  assign load_hold = IncA & ~WEA & ~WEB;

  assign DOutA   = ram_a[AddrA];
  assign DOutB   = ram_b[AddrB];
  assign max_val = (hold > DOutA) ? hold : DOutA;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) ram_a[i] <= '0;
      for (int i = 0; i < 4; i++) ram_b[i] <= '0;
      AddrA <= '0;
      AddrB <= '0;
      hold  <= '0;
      Done  <= 1'b0;
      Error <= 1'b0;
    end else begin
      if (wr_a) ram_a[AddrA] <= DataIn;
      if (wr_b) ram_b[AddrB] <= max_val;
      if (IncA) AddrA <= AddrA + 3'd1;
      if (IncB) AddrB <= AddrB + 2'd1;
      if (load_hold) hold <= DOutA;
      if (wr_a) Done <= 1'b0;
      else if (wr_b && AddrB == 2'd3) Done <= 1'b1;
      if (conflict) Error <= 1'b1;
    end
  end

endmodule

// File: doc/ram_datapath.md
RAM_DATAPATH -- requirements
Module: ram_datapath

Interface
REQ-001 Parameter DATA_W, default 8: width of every data word in RAM A, RAM B, DataIn, DOutA, DOutB and Hold.
REQ-002 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port Reset, input, 1: reset, asynchronous, active-high.
REQ-004 Port WEA, input, 1: write strobe for RAM A.
REQ-005 Port IncA, input, 1: increment strobe for AddrA.
REQ-006 Port WEB, input, 1: write strobe for RAM B.
REQ-007 Port IncB, input, 1: increment strobe for AddrB.
REQ-008 Port DataIn, input, DATA_W: word written into RAM A.
REQ-009 Port AddrA, output, 3: current RAM A address.
REQ-010 Port AddrB, output, 2: current RAM B address.
REQ-011 Port DOutA, output, DATA_W: A[AddrA], combinational read.
REQ-012 Port DOutB, output, DATA_W: B[AddrB], combinational read.
REQ-013 Port Done, output, 1: high after the 4th RAM B write (AddrB==3); sticky.
REQ-014 Port Error, output, 1: sticky protocol-violation flag.

Function
REQ-015 The block SHALL hold RAM A (8 x DATA_W), RAM B (4 x DATA_W) and register Hold (DATA_W), all in flops.
REQ-016 WEA=1 and WEB=0: the block SHALL write A[AddrA] <= DataIn at the edge, using the pre-increment address.
REQ-017 IncA=1: AddrA SHALL increment by 1 at the edge, wrapping 7->0; with WEA=1 in the same cycle, the write SHALL use the old address.
REQ-018 IncA=1, WEA=0, WEB=0: Hold SHALL load DOutA (old AddrA) at the edge; otherwise Hold SHALL keep its value.
REQ-019 WEB=1 and WEA=0: the block SHALL write B[AddrB] <= max(Hold, DOutA), unsigned compare, ties giving the common value.
REQ-020 IncB=1: AddrB SHALL increment by 1, wrapping 3->0; with WEB=1 in the same cycle, the write SHALL use the old address.
REQ-021 Write latency SHALL be one edge: the written value SHALL be visible on DOutA/DOutB in the cycle after the edge if the address is unchanged.
REQ-022 Done SHALL set at the edge of a RAM B write with AddrB==3 and SHALL clear at the edge of any RAM A write; a simultaneous set and clear is impossible per REQ-023.
REQ-023 WEA=1 and WEB=1 in the same cycle: neither RAM SHALL be written, Hold SHALL be unchanged, Error SHALL set, and IncA/IncB SHALL still apply.
REQ-024 Error SHALL remain set until Reset.
REQ-025 All strobes low: all state SHALL hold.

Reset
REQ-026 Reset=1 SHALL immediately, without a clock, force AddrA=0, AddrB=0, Hold=0, Done=0, Error=0 and all RAM A/B words to 0.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence; no write SHALL occur on an edge while Reset=1.
REQ-028 After Reset deasserts, the first edge SHALL act on the strobes normally.

Verification
REQ-029 Reset then idle: DOutA=0, DOutB=0, AddrA=0, AddrB=0, Done=0, Error=0; assert Reset between edges: outputs clear before the next edge.
REQ-030 8 cycles WEA=IncA=1 with DataIn 5,9,3,3,200,17,0,255: AddrA wraps to 0; reading A[0..7] by IncA returns the same values in order.
REQ-031 After REQ-030, repeat 4x {IncA only; WEB only; IncA+IncB}: RAM B = 9,3,200,255; Done=1 after the 4th WEB edge; AddrB=0 at the end.
REQ-032 Then one WEA write: Done=0 at that edge; RAM B unchanged.
REQ-033 WEA=WEB=IncA=1 for one cycle: no RAM change, AddrA increments, Error=1; Error stays 1 through 10 further cycles until Reset.
REQ-034 Reset pulsed after the 2nd WEB of REQ-031: AddrB=0, B all 0, Done=0; restarting the sequence yields REQ-031 results.
